// File: rtl/mriscv_axi_ram_pkg.sv
// Shared types for the AXI4-Lite word RAM:
// write/read engine state encodings and bus widths.
package mriscv_axi_ram_pkg;

  localparam int STRB_W = 4;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    W_IDLE,
    W_WAIT_W,
    W_WAIT_AW,
    W_RESP
  } wstate_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rstate_e;

endpackage

// File: rtl/mriscv_ram_bytewe.sv
// DEPTH x 32 synchronous RAM: byte-enabled write port,
// registered read port returning pre-write contents.
module mriscv_ram_bytewe
  import mriscv_axi_ram_pkg::*;
#(
  parameter int unsigned DEPTH = 1024,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [STRB_W-1:0] be,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rdata_d;

  always_ff @(posedge clk) begin
    for (int i = 0; i < STRB_W; i++) begin
      if (be[i]) begin
        mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Array read sees the old word on a same-edge write.
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem[raddr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mriscv_axi_ram.sv
// AXI4-Lite slave word RAM: independent write and read
// engines, byte strobes and out-of-range error pulse.
module mriscv_axi_ram
  import mriscv_axi_ram_pkg::*;
#(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [31:0]       AWdata,
  input  logic              AWvalid,
  output logic              AWready,
  input  logic [2:0]        AWprot,
  input  logic [DATA_W-1:0] Wdata,
  input  logic [STRB_W-1:0] Wstrb,
  input  logic              Wvalid,
  output logic              Wready,
  output logic              Bvalid,
  input  logic              Bready,
  input  logic [31:0]       ARdata,
  input  logic              ARvalid,
  output logic              ARready,
  input  logic [2:0]        ARprot,
  output logic [DATA_W-1:0] Rdata,
  output logic              Rvalid,
  input  logic              RReady,
  output logic              err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [32:0] LO = {1'b0, BASE_ADDR};
  localparam logic [32:0] HI = LO + 33'(4 * DEPTH);

  wstate_e ws_q, ws_d;
  rstate_e rs_q, rs_d;

  logic              rdy_q;
  logic [31:0]       awaddr_q, awaddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  logic              rd_oor_q, rd_oor_d;
  logic              err_q, err_d;

  logic              aw_hs, w_hs, ar_hs;
  logic              wr_fire;
  logic [31:0]       wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [STRB_W-1:0] wr_strb;
  logic              wr_in, rd_in;
  logic [31:0]       wr_off, rd_off;
  logic [DATA_W-1:0] ram_rdata;

  assign wr_in  = ({1'b0, wr_addr} >= LO) && ({1'b0, wr_addr} < HI);
  assign rd_in  = ({1'b0, ARdata} >= LO) && ({1'b0, ARdata} < HI);
  assign wr_off = wr_addr - BASE_ADDR;
  assign rd_off = ARdata - BASE_ADDR;

  logic unused_ok;
  assign unused_ok = ^{AWprot, ARprot,
                       wr_off[1:0], wr_off[31:AW+2],
                       rd_off[1:0], rd_off[31:AW+2]};

  // Readies stay low until the first edge after reset release.
  always_comb begin
    AWready = rdy_q && (ws_q == W_IDLE || ws_q == W_WAIT_AW);
    Wready  = rdy_q && (ws_q == W_IDLE || ws_q == W_WAIT_W);
    Bvalid  = (ws_q == W_RESP);
    ARready = rdy_q && (rs_q == R_IDLE);
    Rvalid  = (rs_q == R_DATA);
    aw_hs   = AWvalid && AWready;
    w_hs    = Wvalid && Wready;
    ar_hs   = ARvalid && ARready;
  end

  always_comb begin
    ws_d     = ws_q;
    awaddr_d = awaddr_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    wr_fire  = 1'b0;
    wr_addr  = awaddr_q;
    wr_data  = wdata_q;
    wr_strb  = wstrb_q;
    unique case (ws_q)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          wr_fire = 1'b1;
          wr_addr = AWdata;
          wr_data = Wdata;
          wr_strb = Wstrb;
          ws_d    = W_RESP;
        end else if (aw_hs) begin
          awaddr_d = AWdata;
          ws_d     = W_WAIT_W;
        end else if (w_hs) begin
          wdata_d = Wdata;
          wstrb_d = Wstrb;
          ws_d    = W_WAIT_AW;
        end
      end
      W_WAIT_W: begin
        if (w_hs) begin
          wr_fire = 1'b1;
          wr_data = Wdata;
          wr_strb = Wstrb;
          ws_d    = W_RESP;
        end
      end
      W_WAIT_AW: begin
        if (aw_hs) begin
          wr_fire = 1'b1;
          wr_addr = AWdata;
          ws_d    = W_RESP;
        end
      end
      W_RESP: begin
        if (Bready) begin
          ws_d = W_IDLE;
        end
      end
      default: ws_d = W_IDLE;
    endcase
  end

  always_comb begin
    rs_d     = rs_q;
    rd_oor_d = rd_oor_q;
    if (rs_q == R_IDLE) begin
      if (ar_hs) begin
        rs_d     = R_DATA;
        rd_oor_d = !rd_in;
      end
    end else if (RReady) begin
      rs_d = R_IDLE;
    end
    err_d = (wr_fire && !wr_in) || (ar_hs && !rd_in);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdy_q    <= 1'b0;
      ws_q     <= W_IDLE;
      rs_q     <= R_IDLE;
      awaddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      rd_oor_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      rdy_q    <= 1'b1;
      ws_q     <= ws_d;
      rs_q     <= rs_d;
      awaddr_q <= awaddr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      rd_oor_q <= rd_oor_d;
      err_q    <= err_d;
    end
  end

  mriscv_ram_bytewe #(
    .DEPTH(DEPTH)
  ) u_ram (
    .clk   (clk),
    .rst_n (rstn),
    .be    (wr_strb & {STRB_W{wr_fire && wr_in}}),
    .waddr (wr_off[AW+1:2]),
    .wdata (wr_data),
    .re    (ar_hs && rd_in),
    .raddr (rd_off[AW+1:2]),
    .rdata (ram_rdata)
  );

  assign Rdata = rd_oor_q ? '0 : ram_rdata;
  assign err   = err_q;

endmodule

// File: tb/tb_mriscv_axi_ram.sv
// Directed bench for mriscv_axi_ram with a read-data
// scoreboard and a byte-strobe memory model.
module tb_mriscv_axi_ram;

  localparam int unsigned DEPTH = 32;
  localparam logic [31:0] B = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] AWdata = '0;
  logic        AWvalid = 1'b0;
  logic        AWready;
  logic [2:0]  AWprot = '0;
  logic [31:0] Wdata = '0;
  logic [3:0]  Wstrb = '0;
  logic        Wvalid = 1'b0;
  logic        Wready;
  logic        Bvalid;
  logic        Bready = 1'b0;
  logic [31:0] ARdata = '0;
  logic        ARvalid = 1'b0;
  logic        ARready;
  logic [2:0]  ARprot = '0;
  logic [31:0] Rdata;
  logic        Rvalid;
  logic        RReady = 1'b0;
  logic        err;

  int n_chk = 0;
  int n_pass = 0;
  logic [31:0] model [DEPTH];
  logic [31:0] sb [$];
  logic [31:0] e;

  always #5 clk = ~clk;

  mriscv_axi_ram #(
    .DEPTH(DEPTH),
    .BASE_ADDR(B)
  ) dut (
    .clk(clk), .rstn(rstn),
    .AWdata(AWdata), .AWvalid(AWvalid),
    .AWready(AWready), .AWprot(AWprot),
    .Wdata(Wdata), .Wstrb(Wstrb),
    .Wvalid(Wvalid), .Wready(Wready),
    .Bvalid(Bvalid), .Bready(Bready),
    .ARdata(ARdata), .ARvalid(ARvalid),
    .ARready(ARready), .ARprot(ARprot),
    .Rdata(Rdata), .Rvalid(Rvalid),
    .RReady(RReady), .err(err)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h",
                tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic int idx(input logic [31:0] a);
    logic [31:0] o;
    o = (a - B) >> 2;
    return int'(o);
  endfunction

  task automatic model_wr(input logic [31:0] a,
                          input logic [31:0] d,
                          input logic [3:0] s);
    for (int i = 0; i < 4; i++) begin
      if (s[i]) model[idx(a)][8*i +: 8] = d[8*i +: 8];
    end
  endtask

  task automatic pop_chk(input string tag);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk(tag, Rdata, e);
    end
  endtask

  task automatic do_write(input logic [31:0] a,
                          input logic [31:0] d,
                          input logic [3:0] s,
                          input int stall,
                          input logic xerr);
    chk("w_awready", AWready, 1);
    chk("w_wready", Wready, 1);
    AWvalid = 1; AWdata = a;
    Wvalid = 1; Wdata = d; Wstrb = s;
    tick();
    AWvalid = 0; Wvalid = 0;
    if (!xerr) model_wr(a, d, s);
    chk("w_bvalid", Bvalid, 1);
    chk("w_err", err, xerr);
    for (int i = 0; i < stall; i++) begin
      AWvalid = 1; AWdata = B + 32'h4;
      tick();
      chk("w_bhold", Bvalid, 1);
      chk("w_awblock", AWready, 0);
    end
    AWvalid = 0;
    Bready = 1;
    tick();
    Bready = 0;
    chk("w_bdone", Bvalid, 0);
    chk("w_awback", AWready, 1);
    chk("w_errlow", err, 0);
  endtask

  task automatic do_read(input logic [31:0] a,
                         input int stall,
                         input logic xerr);
    sb.push_back(xerr ? 32'd0 : model[idx(a)]);
    chk("r_arready", ARready, 1);
    ARvalid = 1; ARdata = a;
    tick();
    ARvalid = 0;
    chk("r_rvalid", Rvalid, 1);
    chk("r_err", err, xerr);
    pop_chk("r_rdata");
    for (int i = 0; i < stall; i++) begin
      ARvalid = 1; ARdata = B + 32'h8;
      tick();
      chk("r_rhold", Rvalid, 1);
      chk("r_arblock", ARready, 0);
      chk("r_dhold", Rdata, e);
    end
    ARvalid = 0;
    RReady = 1;
    tick();
    RReady = 0;
    chk("r_rdone", Rvalid, 0);
    chk("r_arback", ARready, 1);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_awready"}, AWready, 0);
    chk({tag, "_wready"}, Wready, 0);
    chk({tag, "_arready"}, ARready, 0);
    chk({tag, "_bvalid"}, Bvalid, 0);
    chk({tag, "_rvalid"}, Rvalid, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_rdata"}, Rdata, 0);
  endtask

  initial begin
    for (int i = 0; i < int'(DEPTH); i++) model[i] = '0;
    #3;
    chk_reset_outs("rst");
    @(negedge clk);
    rstn = 1;
    #1;
    chk("rel_awready", AWready, 0);
    @(negedge clk);
    chk("up_awready", AWready, 1);
    chk("up_wready", Wready, 1);
    chk("up_arready", ARready, 1);

    do_write(B, 32'hCAFE_0000, 4'hF, 0, 0);
    do_write(B + 32'h7C, 32'h7C7C_7C7C, 4'hF, 0, 0);

    do_write(B + 32'h10, 32'hDEAD_BEEF, 4'hF, 0, 0);
    do_read(B + 32'h10, 0, 0);

    do_write(B + 32'h20, 32'h0, 4'hF, 0, 0);
    Wvalid = 1; Wdata = 32'h1122_3344; Wstrb = 4'b0101;
    tick();
    Wvalid = 0;
    chk("wf_wready", Wready, 0);
    for (int i = 0; i < 2; i++) begin
      chk("wf_awready", AWready, 1);
      chk("wf_bvalid", Bvalid, 0);
      tick();
    end
    chk("wf_awready3", AWready, 1);
    AWvalid = 1; AWdata = B + 32'h20;
    tick();
    AWvalid = 0;
    model_wr(B + 32'h20, 32'h1122_3344, 4'b0101);
    chk("wf_bvalid", Bvalid, 1);
    chk("wf_awresp", AWready, 0);
    Bready = 1;
    tick();
    Bready = 0;
    chk("wf_awidle", AWready, 1);
    do_read(B + 32'h20, 0, 0);
    chk("wf_value", e, 32'h0022_0044);

    do_write(B + 32'h30, 32'h3030_3030, 4'hF, 5, 0);
    do_read(B + 32'h10, 5, 0);

    do_write(B + 32'h80, 32'hBAD0_BAD0, 4'hF, 0, 1);
    do_read(B - 32'h4, 0, 1);
    do_read(B + 32'h7C, 0, 0);
    do_read(B, 0, 0);
    chk("oor_untouched", e, 32'hCAFE_0000);

    AWvalid = 1; AWdata = B + 32'h80;
    Wvalid = 1; Wdata = 32'h1; Wstrb = 4'hF;
    ARvalid = 1; ARdata = B + 32'h84;
    sb.push_back(32'd0);
    tick();
    AWvalid = 0; Wvalid = 0; ARvalid = 0;
    chk("dual_err", err, 1);
    chk("dual_bvalid", Bvalid, 1);
    chk("dual_rvalid", Rvalid, 1);
    pop_chk("dual_rdata");
    Bready = 1; RReady = 1;
    tick();
    Bready = 0; RReady = 0;
    chk("dual_errlow", err, 0);

    do_write(B + 32'h40, 32'hA, 4'hF, 0, 0);
    sb.push_back(model[idx(B + 32'h40)]);
    AWvalid = 1; AWdata = B + 32'h40;
    Wvalid = 1; Wdata = 32'hB; Wstrb = 4'hF;
    ARvalid = 1; ARdata = B + 32'h40;
    tick();
    AWvalid = 0; Wvalid = 0; ARvalid = 0;
    model_wr(B + 32'h40, 32'hB, 4'hF);
    chk("rbw_bvalid", Bvalid, 1);
    chk("rbw_rvalid", Rvalid, 1);
    pop_chk("rbw_old");
    chk("rbw_oldval", e, 32'hA);
    Bready = 1; RReady = 1;
    tick();
    Bready = 0; RReady = 0;
    do_read(B + 32'h40, 0, 0);
    chk("rbw_newval", e, 32'hB);

    AWvalid = 1; AWdata = B + 32'h10;
    ARvalid = 1; ARdata = B + 32'h10;
    tick();
    AWvalid = 0; ARvalid = 0;
    chk("mid_rvalid", Rvalid, 1);
    chk("mid_wready", Wready, 1);
    chk("mid_awready", AWready, 0);
    #1;
    rstn = 0;
    #1;
    chk_reset_outs("arst");
    @(negedge clk);
    chk_reset_outs("hold");
    #1;
    rstn = 1;
    #1;
    chk("rel2_arready", ARready, 0);
    @(negedge clk);
    chk("up2_awready", AWready, 1);
    chk("up2_wready", Wready, 1);
    chk("up2_arready", ARready, 1);
    chk("up2_bvalid", Bvalid, 0);
    do_read(B + 32'h10, 0, 0);
    chk("kept_10", e, 32'hDEAD_BEEF);
    do_read(B + 32'h20, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mriscv_axi_ram.md
# mriscv_axi_ram

AXI4-Lite slave word memory serving the core's AXI4-Lite master port: accepts the core's address/write/read channels and returns read data and write responses. Independent write and read engines run concurrently on one single-port-write / single-port-read synchronous RAM, with byte-strobe writes and out-of-range detection. It is the memory stage directly downstream of the core's memory interface. On the AXI4-Lite ports, the channel address appears on the `AWdata`/`ARdata` buses.

## Interface
- `DEPTH`, 1024 — number of 32-bit words; power of two, ≥ 4.
- `BASE_ADDR`, 32'h0000_0000 — byte address of word 0; `4*DEPTH`-aligned.
- `clk` in 1 — single clock, rising edge.
- `rstn` in 1 — reset, asynchronous assert, active-low.
- `AWdata` in 32 — write byte address.
- `AWvalid` in 1 / `AWready` out 1 — write-address handshake.
- `AWprot` in 3 — accepted and ignored.
- `Wdata` in 32 — write data.
- `Wstrb` in 4 — byte enables; bit i enables `Wdata[8i+7:8i]`.
- `Wvalid` in 1 / `Wready` out 1 — write-data handshake.
- `Bvalid` out 1 / `Bready` in 1 — write-response handshake (no response code).
- `ARdata` in 32 — read byte address.
- `ARvalid` in 1 / `ARready` out 1 — read-address handshake.
- `ARprot` in 3 — accepted and ignored.
- `Rdata` out 32 — read data.
- `Rvalid` out 1 / `RReady` in 1 — read-data handshake.
- `err` out 1 — one-cycle pulse per out-of-range access.

## Operation
- Handshake = valid & ready high at a rising edge. Readies never depend combinationally on valids.
- Word index = `(addr - BASE_ADDR) >> 2`; `addr[1:0]` ignored.
- In range iff `BASE_ADDR <= addr < BASE_ADDR + 4*DEPTH`; comparison in 33-bit arithmetic, no wrap.
- Write FSM states:
  - `W_IDLE`: `AWready`=`Wready`=1.
  - `W_WAIT_W`: AW taken; `Wready`=1.
  - `W_WAIT_AW`: W taken; `AWready`=1.
  - `W_RESP`: `Bvalid`=1.
- Write transitions:
  - Both AW and W handshake in `W_IDLE` → write on that edge → `W_RESP`.
  - AW only → `W_WAIT_W`; W only → `W_WAIT_AW`. Address/data/strobes are registered.
  - Completing handshake → write on that edge → `W_RESP`.
  - `W_RESP` → `W_IDLE` on `Bvalid & Bready`.
  - All-zero `Wstrb`: no bytes change; response still issued.
- Read FSM states:
  - `R_IDLE`: `ARready`=1.
  - `R_DATA`: `Rvalid`=1.
- Read transitions:
  - AR handshake → RAM read and `Rdata` loaded on that edge → `R_DATA`.
  - `R_DATA`: `Rdata` held stable until `Rvalid & RReady`, then → `R_IDLE`.
- Out-of-range write: RAM untouched, `err` pulses, normal B response.
- Out-of-range read: `Rdata`=0, `err` pulses, normal R response.
- Out-of-range read and write on the same edge: single `err` pulse.
- Read and write to the same word on the same edge: read returns old data (read-before-write).

## Timing
- Reset values:
  - `AWready`, `Wready`, `ARready`, `Bvalid`, `Rvalid`, `err` = 0; `Rdata` = 0.
  - RAM contents are not reset.
- Readies rise on the first rising edge after `rstn` deasserts (FSMs reset to IDLE, readies gated by a registered reset-done flag).
- Write latency: `Bvalid` high the cycle after the last of the AW/W handshakes.
- Read latency: `Rvalid` high the cycle after the AR handshake.
- Back-to-back throughput: one write per 2 cycles with `Bready` tied high; same for reads with `RReady` tied high. IDLE readies reassert the cycle after the response handshake.
- Write and read channels are fully independent; no ordering between them.
- `err` is asserted the cycle after the offending write commit or AR handshake.
- `rstn` low mid-transaction:
  - All outputs go to reset values immediately.
  - Partial (half-handshaken) writes are discarded.
  - Words already committed are retained.

## Structure
- Package `mriscv_axi_ram_pkg`:
  - write-state and read-state enums (2-bit / 1-bit),
  - `STRB_W`=4, `DATA_W`=32.
- Sub-module `mriscv_ram_bytewe`: `DEPTH`×32 synchronous RAM, one byte-enabled write port, one registered read port with read-before-write.
- Top holds both FSMs, address decode and the `err` logic.

## Test plan
- Write 32'hDEAD_BEEF to 0x10, strobe 4'hF, AW and W in the same cycle → `Bvalid` one cycle later; read 0x10 → `Rvalid` one cycle after AR, `Rdata`=32'hDEAD_BEEF.
- W three cycles before AW (0x20, 32'h1122_3344, strobe 4'b0101) over a word holding 0 → read 0x20 returns 32'h0022_0044; `AWready` low only while in `W_RESP`.
- `Bready`/`RReady` held low 5 cycles → `Bvalid`/`Rvalid` and `Rdata` stable throughout; no new AW/AR accepted.
- Write to `BASE_ADDR + 4*DEPTH` and read from `BASE_ADDR - 4` → each gives one `err` pulse, `Rdata`=0, RAM unchanged; read of `BASE_ADDR + 4*DEPTH - 4` succeeds with no `err`.
- Same-edge read and write to 0x40 (old 32'hA, new 32'hB) → read returns 32'hA; a following read returns 32'hB.
- `rstn` pulsed low while in `W_WAIT_W` and `R_DATA` → all valids/readies 0 asynchronously, readies back one edge after release, earlier committed data intact.
